// File: rtl/counter_cmd_driver_pkg.sv
// Shared types and default sizes for the counter command driver and its reference model.
package counter_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_HOLD = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LDST   = 2'd1,
    RUN    = 2'd2,
    HOLDST = 2'd3
  } drv_state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/counter_cmd_driver_if.sv
// Command handshake between a command source (master) and the counter driver (slave).
interface counter_cmd_driver_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_value;
  logic [LEN_W-1:0] cmd_len;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_value, cmd_len,
    input  cmd_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_value, cmd_len,
    output cmd_ready, busy, done
  );
endinterface

// File: rtl/counter_cmd_driver_ref_model.sv
// Cycle-accurate model of the loadable up/down counter plus mismatch capture.
module counter_ref_model
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_out,
  input  logic             clr_err,
  output logic [WIDTH-1:0] exp_val,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] r_exp;
  logic             r_exp_valid;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_err_exp;
  logic [WIDTH-1:0] r_err_got;

  logic             w_mismatch;
  logic [ERR_W-1:0] w_cnt_base;

  // Counter contents are unknown until the first load after reset.
  assign w_mismatch = r_exp_valid && (data_out != r_exp);
  // A clear in the same cycle as a mismatch makes it a fresh first error.
  assign w_cnt_base = clr_err ? '0 : r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exp       <= '0;
      r_exp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_err_exp   <= '0;
      r_err_got   <= '0;
    end else begin
      r_exp       <= load ? data_in : (up_down ? r_exp + ONE : r_exp - ONE);
      r_exp_valid <= r_exp_valid | load;
      if (clr_err) begin
        r_err     <= 1'b0;
        r_err_cnt <= '0;
        r_err_exp <= '0;
        r_err_got <= '0;
      end
      if (w_mismatch) begin
        r_err     <= 1'b1;
        r_err_cnt <= (w_cnt_base == ERR_MAX) ? ERR_MAX : w_cnt_base + 1'b1;
        if (clr_err || !r_err) begin
          r_err_exp <= r_exp;
          r_err_got <= data_out;
        end
      end
    end
  end

  assign exp_val = r_exp;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign err_exp = r_err_exp;
  assign err_got = r_err_got;
endmodule

// File: rtl/counter_cmd_driver.sv
// Command-driven stimulus source and checker for the loadable up/down counter.
module counter_cmd_driver
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_cmd_driver_if.slave  cmd,
  output logic                 load,
  output logic [WIDTH-1:0]     data_in,
  output logic                 up_down,
  input  logic [WIDTH-1:0]     data_out,
  input  logic                 clr_err,
  output logic                 err,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [WIDTH-1:0]     err_exp,
  output logic [WIDTH-1:0]     err_got
);
  drv_state_e       r_state;
  logic [LEN_W-1:0] r_rem;
  logic             r_dir;
  logic [WIDTH-1:0] r_val;
  logic             r_done;

  logic [WIDTH-1:0] w_exp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_val   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              OP_LOAD: begin
                r_val   <= cmd.cmd_value;
                r_state <= LDST;
              end
              OP_UP, OP_DOWN: begin
                if (cmd.cmd_len == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_dir   <= (cmd.cmd_op == OP_UP);
                  r_rem   <= cmd.cmd_len;
                  r_state <= RUN;
                end
              end
              default: begin
                if (cmd.cmd_len == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_rem   <= cmd.cmd_len;
                  r_state <= HOLDST;
                end
              end
            endcase
          end
        end
        LDST: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: begin
          // RUN and HOLDST both last exactly the captured length.
          r_rem <= r_rem - 1'b1;
          if (r_rem == LEN_W'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Counter pins come from state only; reset forces them low.
  assign load    = rst && (r_state != RUN);
  assign data_in = !rst ? '0 : ((r_state == LDST) ? r_val : w_exp);
  assign up_down = rst && (r_state == RUN) && r_dir;

  assign cmd.cmd_ready = (r_state == IDLE);
  assign cmd.busy      = (r_state != IDLE);
  assign cmd.done      = r_done;

  counter_ref_model #(
    .WIDTH (WIDTH),
    .ERR_W (ERR_W)
  ) u_ref (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .up_down  (up_down),
    .data_out (data_out),
    .clr_err  (clr_err),
    .exp_val  (w_exp),
    .err      (err),
    .err_cnt  (err_cnt),
    .err_exp  (err_exp),
    .err_got  (err_got)
  );
endmodule

// File: doc/counter_cmd_driver.md
Name: counter_cmd_driver

Overview:
- Command-driven stimulus and checker for the loadable up/down counter (counter_load). It is the other end of the counter's load/data_in/up_down/data_out interface.
- Accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and drives the counter's control pins.
- Runs a cycle-accurate reference model of the counter and flags every cycle where the counter's data_out disagrees with the model.
- Sits beside counter_load in the counter subsystem and is used for built-in self-test and as a synthesizable traffic source.

Parameters:
WIDTH, 4, counter data width (data_in/data_out/cmd_value)
LEN_W, 8, width of the command repeat length
ERR_W, 8, width of the saturating mismatch counter

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  driver can accept a command (high only in IDLE)
cmd_op  input  2  0=LOAD, 1=UP, 2=DOWN, 3=HOLD
cmd_value  input  WIDTH  load value (LOAD only)
cmd_len  input  LEN_W  cycle count (UP/DOWN/HOLD)
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse when a command completes
load  output  1  to counter: load data_in
data_in  output  WIDTH  to counter: load value
up_down  output  1  to counter: 1=count up, 0=count down
data_out  input  WIDTH  from counter: current count
clr_err  input  1  synchronous clear of error state
err  output  1  sticky mismatch flag
err_cnt  output  ERR_W  saturating mismatch count
err_exp  output  WIDTH  expected value at the first mismatch
err_got  output  WIDTH  observed value at the first mismatch

Behaviour:
- Counter contract, per rising edge: if load, the count becomes data_in. Otherwise the count becomes count+1 (up_down=1) or count-1 (up_down=0), mod 2^WIDTH.
- Reset (rst=0, async):
  - state=IDLE, exp=0, exp_valid=0, rem=0, done=0.
  - err=0, err_cnt=0, err_exp=0, err_got=0.
  - While reset is asserted: load=0, data_in=0, up_down=0.
  - Reset mid-command abandons the command silently; done is not pulsed.
- Outputs load/data_in/up_down/cmd_ready/busy are decoded from registered state only (Moore). There is no combinational path from cmd_* to the counter pins.
- States:
  - IDLE (park): load=1, data_in=exp, up_down=0, cmd_ready=1. On cmd_valid & cmd_ready:
    - LOAD -> LDST, capturing val=cmd_value.
    - UP/DOWN with cmd_len!=0 -> RUN, with dir=(op==UP) and rem=cmd_len.
    - HOLD with cmd_len!=0 -> HOLDST, with rem=cmd_len.
    - UP/DOWN/HOLD with cmd_len==0 -> stay IDLE; done pulses next cycle (no-op).
  - LDST (1 cycle): load=1, data_in=val -> IDLE; done=1.
  - RUN: load=0, up_down=dir. rem decrements each cycle; at rem==1 -> IDLE with done=1. Exactly cmd_len count edges occur.
  - HOLDST: load=1, data_in=exp (counter holds). Same rem rule as RUN.
- done is registered: high for the single cycle where state is first back in IDLE.
- Reference model, every edge while rst=1: exp <= load ? data_in : (up_down ? exp+1 : exp-1), wrapping. exp_valid <= exp_valid | load.
- Check, every edge with exp_valid=1: compare data_out against exp as both stood before the edge. On mismatch:
  - err <= 1.
  - err_cnt <= err_cnt+1, saturating at 2^ERR_W-1.
  - If err was 0, capture err_exp=exp and err_got=data_out.
  - No check is made before the first load after reset.
- clr_err clears err, err_cnt, err_exp and err_got. A mismatch in the same cycle is then recorded as a fresh first error (err=1, err_cnt=1).
- Wrap-around is legal: UP from 4'hF gives 4'h0, and DOWN from 4'h0 gives 4'hF; neither is an error.
- A cmd_valid held while busy is not accepted; the command must remain stable until cmd_ready.

Decomposition:
- Package counter_pkg:
  - enum cmd_op_e {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD}
  - enum drv_state_e {IDLE, LDST, RUN, HOLDST}
  - default WIDTH/LEN_W/ERR_W constants
- One sub-module, counter_ref_model: exp/exp_valid register plus the compare and error capture logic. The FSM and command handshake stay in the top.

Test Plan:
- Reset release, idle 5 cycles, counter healthy -> load=1 each cycle, data_in=0, err=0, cmd_ready=1.
- LOAD 4'hA, then UP len=3 -> data_out sequence A,B,C,D; done pulses after the LOAD and after the UP; err=0.
- LOAD 4'h1, then DOWN len=3 -> 1,0,F,E (wrap); exp ends 4'hE; err=0.
- HOLD len=4 after LOAD 4'h7 -> data_out stays 7 for 4 cycles; busy=1 for exactly 4 cycles; UP len=0 -> done next cycle, no count change.
- Force data_out to 4'h3 while exp=4'h5 for 2 cycles -> err=1, err_cnt=2, err_exp=5, err_got=3; then clr_err -> all cleared.
- Assert rst mid-RUN (rem=5) -> outputs zero immediately, no done; after release, IDLE with exp_valid=0 until the first park load.
